noc_input_vc_buffer: RTL and testbench

//  Router input stage: one per router input port, directly upstream of the route selector.

---
 rtl/noc_input_vc_buffer_pkg.sv | 10 +
 rtl/noc_vc_fifo.sv | 53 +++++
 rtl/noc_input_vc_buffer.sv | 81 ++++++++
 tb/tb_noc_input_vc_buffer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/noc_input_vc_buffer_pkg.sv
// Shared NoC router parameters and types used by the input VC buffer.
package Noc_parameters;

    localparam int unsigned Noc_VC_Channel      = 2;
    localparam int unsigned Noc_Data_Width      = 8;
    localparam int unsigned Noc_VC_Buffer_Depth = 4;

    typedef logic [$clog2(Noc_VC_Channel)-1:0] t_vc_id;

endpackage

// File: rtl/noc_vc_fifo.sv
// Single-VC synchronous FIFO: register array storage, wrapping pointers, 0..DEPTH count.
module noc_vc_fifo #(
    parameter  int unsigned DEPTH      = 4,
    parameter  int unsigned DATA_WIDTH = 8,
    localparam int unsigned PTR_W      = $clog2(DEPTH),
    localparam int unsigned CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  full,
    output logic                  empty,
    output logic [CNT_W-1:0]      count,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    // Acceptance is judged on the start-of-cycle count, so a full FIFO refuses even while popping.
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Flit storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data;
    end

endmodule

// File: rtl/noc_input_vc_buffer.sv
// Router input stage: demultiplexes link flits into per-VC FIFOs and exposes each VC head independently.
module noc_input_vc_buffer
    import Noc_parameters::*;
#(
    parameter  int unsigned CHANNELS   = Noc_VC_Channel,
    parameter  int unsigned DEPTH      = Noc_VC_Buffer_Depth,
    parameter  int unsigned DATA_WIDTH = Noc_Data_Width,
    localparam int unsigned VC_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int unsigned CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                           noc_clk,
    input  logic                           noc_rst_n,
    input  logic                           in_valid,
    input  logic [VC_W-1:0]                in_vc,
    input  logic [DATA_WIDTH-1:0]          in_flit,
    output logic [CHANNELS-1:0]            vc_ready,
    output logic [CHANNELS-1:0]            out_valid,
    output logic [CHANNELS*DATA_WIDTH-1:0] out_flit,
    input  logic [CHANNELS-1:0]            out_ready,
    output logic [CHANNELS*CNT_W-1:0]      occupancy,
    output logic                           err_overflow
);

    logic [CHANNELS-1:0] full;
    logic [CHANNELS-1:0] empty;
    logic [CHANNELS-1:0] push;
    logic                vc_ok;
    logic                drop;

    assign vc_ok = (32'(in_vc) < CHANNELS);

    // Decode the link flit into a one-hot push, or flag it as dropped.
    always_comb begin
        push = '0;
        drop = 1'b0;
        if (in_valid) begin
            if (!vc_ok) begin
                drop = 1'b1;
            end else if (full[in_vc]) begin
                drop = 1'b1;
            end else begin
                push[in_vc] = 1'b1;
            end
        end
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            err_overflow <= 1'b0;
        end else if (drop) begin
            err_overflow <= 1'b1;
        end
    end

    for (genvar v = 0; v < CHANNELS; v++) begin : g_vc
        logic [CNT_W-1:0]      cnt;
        logic [DATA_WIDTH-1:0] head;

        noc_vc_fifo #(
            .DEPTH      (DEPTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_fifo (
            .clk   (noc_clk),
            .rst_n (noc_rst_n),
            .push  (push[v]),
            .pop   (out_ready[v]),
            .data  (in_flit),
            .full  (full[v]),
            .empty (empty[v]),
            .count (cnt),
            .head  (head)
        );

        // All per-VC outputs derive from registered FIFO state only.
        assign vc_ready[v]                            = !full[v];
        assign out_valid[v]                           = !empty[v];
        assign out_flit[v*DATA_WIDTH +: DATA_WIDTH]   = head;
        assign occupancy[v*CNT_W +: CNT_W]            = cnt;
    end

endmodule

// File: tb/tb_noc_input_vc_buffer.sv
// Scoreboard bench for noc_input_vc_buffer: per-VC expected queues, negedge monitor, random and directed traffic.
module tb_noc_input_vc_buffer;
    import Noc_parameters::*;

    localparam int unsigned CH    = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned VC_W  = 1;
    localparam int unsigned CNT_W = 3;

    logic                noc_clk   = 1'b0;
    logic                noc_rst_n = 1'b0;
    logic                in_valid  = 1'b0;
    logic [VC_W-1:0]     in_vc     = '0;
    logic [DW-1:0]       in_flit   = '0;
    logic [CH-1:0]       out_ready = '0;
    logic [CH-1:0]       vc_ready;
    logic [CH-1:0]       out_valid;
    logic [CH*DW-1:0]    out_flit;
    logic [CH*CNT_W-1:0] occupancy;
    logic                err_overflow;

    always #5 noc_clk = ~noc_clk;

    noc_input_vc_buffer #(
        .CHANNELS   (CH),
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DW)
    ) dut (
        .noc_clk      (noc_clk),
        .noc_rst_n    (noc_rst_n),
        .in_valid     (in_valid),
        .in_vc        (in_vc),
        .in_flit      (in_flit),
        .vc_ready     (vc_ready),
        .out_valid    (out_valid),
        .out_flit     (out_flit),
        .out_ready    (out_ready),
        .occupancy    (occupancy),
        .err_overflow (err_overflow)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: one FIFO queue per VC plus the sticky error flag.
    logic [DW-1:0] sb [CH][$];
    bit            err_model = 1'b0;
    bit            pend_push = 1'b0;
    int            pend_vc   = 0;
    logic [DW-1:0] pend_flit = '0;
    bit            pend_err  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and record what the model expects to be accepted.
    task automatic step(input bit iv, input int vc, input logic [DW-1:0] f, input logic [CH-1:0] rdy);
        @(posedge noc_clk);
        #1;
        in_valid  = iv;
        in_vc     = VC_W'(vc);
        in_flit   = f;
        out_ready = rdy;
        if (iv) begin
            if (vc >= int'(CH) || sb[vc].size() >= int'(DEPTH)) begin
                pend_err = 1'b1;
            end else begin
                pend_push = 1'b1;
                pend_vc   = vc;
                pend_flit = f;
            end
        end
    endtask

    task automatic idle(input int n, input logic [CH-1:0] rdy);
        for (int i = 0; i < n; i++) step(1'b0, 0, '0, rdy);
    endtask

    // Monitor: compare every VC against the model, then retire pops and commit pending pushes.
    always @(negedge noc_clk) begin
        int n;
        if (!noc_rst_n) begin
            for (int v = 0; v < int'(CH); v++) sb[v].delete();
            err_model = 1'b0;
            pend_push = 1'b0;
            pend_err  = 1'b0;
        end else begin
            for (int v = 0; v < int'(CH); v++) begin
                n = sb[v].size();
                chk($sformatf("out_valid[%0d]", v), 64'(out_valid[v]), 64'(n > 0));
                chk($sformatf("occupancy[%0d]", v), 64'(occupancy[v*CNT_W +: CNT_W]), 64'(n));
                chk($sformatf("vc_ready[%0d]", v), 64'(vc_ready[v]), 64'(n < int'(DEPTH)));
                if (n > 0) begin
                    chk($sformatf("out_flit[%0d]", v), 64'(out_flit[v*DW +: DW]), 64'(sb[v][0]));
                    if (out_ready[v]) void'(sb[v].pop_front());
                end
            end
            chk("err_overflow", 64'(err_overflow), 64'(err_model));
            if (pend_push) sb[pend_vc].push_back(pend_flit);
            if (pend_err) err_model = 1'b1;
            pend_push = 1'b0;
            pend_err  = 1'b0;
        end
    end

    initial begin
        #22 noc_rst_n = 1'b1;

        // Reset state
        @(negedge noc_clk);
        chk("reset vc_ready", 64'(vc_ready), 64'(2'b11));
        chk("reset out_valid", 64'(out_valid), 64'(0));
        chk("reset occupancy", 64'(occupancy), 64'(0));
        chk("reset err_overflow", 64'(err_overflow), 64'(0));

        // Single flit to VC1
        step(1'b1, 1, 8'hA5, 2'b00);
        idle(1, 2'b00);
        @(negedge noc_clk);
        chk("single out_valid", 64'(out_valid), 64'(2'b10));
        chk("single out_flit vc1", 64'(out_flit[DW +: DW]), 64'(8'hA5));
        chk("single occupancy vc1", 64'(occupancy[CNT_W +: CNT_W]), 64'(1));
        idle(2, 2'b10);

        // Fill VC0, overflow, drain
        for (int i = 1; i <= 4; i++) step(1'b1, 0, DW'(i), 2'b00);
        idle(1, 2'b00);
        @(negedge noc_clk);
        chk("full vc_ready[0]", 64'(vc_ready[0]), 64'(0));
        step(1'b1, 0, 8'h05, 2'b00);
        idle(1, 2'b00);
        @(negedge noc_clk);
        chk("overflow err", 64'(err_overflow), 64'(1));
        chk("overflow occupancy vc0", 64'(occupancy[0 +: CNT_W]), 64'(4));
        idle(5, 2'b01);

        // Push+pop on a full VC is refused; at count 2 it keeps the count
        for (int i = 6; i <= 9; i++) step(1'b1, 0, DW'(i), 2'b00);
        step(1'b1, 0, 8'h55, 2'b01);
        idle(1, 2'b00);
        @(negedge noc_clk);
        chk("full push+pop count", 64'(occupancy[0 +: CNT_W]), 64'(3));
        idle(1, 2'b01);
        step(1'b1, 0, 8'h66, 2'b01);
        idle(1, 2'b00);
        @(negedge noc_clk);
        chk("count2 push+pop count", 64'(occupancy[0 +: CNT_W]), 64'(2));
        idle(3, 2'b01);

        // Interleaved VCs with random ready, then a stalled VC1
        step(1'b1, 0, 8'd10, CH'($urandom));
        step(1'b1, 1, 8'd20, CH'($urandom));
        step(1'b1, 0, 8'd11, CH'($urandom));
        step(1'b1, 1, 8'd21, CH'($urandom));
        for (int i = 0; i < 4; i++) step(1'b1, 1, DW'(8'h30 + i), 2'b00);
        for (int i = 0; i < 4; i++) step(1'b1, 0, DW'(8'h40 + i), 2'b01);
        idle(12, 2'b11);

        // Wrap-around: continuous push+pop on VC0
        for (int i = 0; i < 20; i++) step(1'b1, 0, DW'(100 + i), 2'b01);
        idle(3, 2'b11);

        // Random traffic: alternating light and heavy backpressure
        for (int i = 0; i < 400; i++) begin
            logic [CH-1:0] rdy;
            rdy = ((i / 50) % 2 == 0) ? CH'($urandom) : CH'($urandom & $urandom & $urandom);
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 1)), DW'($urandom), rdy);
        end
        idle(10, 2'b11);

        // Async reset with VC0 at count 3
        for (int i = 0; i < 3; i++) step(1'b1, 0, DW'(8'h70 + i), 2'b00);
        idle(1, 2'b00);
        @(posedge noc_clk);
        #2 noc_rst_n = 1'b0;
        #1;
        chk("async rst out_valid", 64'(out_valid), 64'(0));
        chk("async rst occupancy", 64'(occupancy), 64'(0));
        chk("async rst vc_ready", 64'(vc_ready), 64'(2'b11));
        chk("async rst err", 64'(err_overflow), 64'(0));
        @(negedge noc_clk);
        #2 noc_rst_n = 1'b1;
        idle(2, 2'b00);
        step(1'b1, 0, 8'h99, 2'b00);
        idle(2, 2'b01);

        @(negedge noc_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
